adder_bist_analyzer: RTL and testbench
======================================

// Module: adder_bist_analyzer
// PURPOSE
//  On-chip exhaustive stimulus sweeper and response analyzer for WIDTH-bit (approximate) adders.
//  Drives every {a,b,cin} combination into a DUT adder, captures {cout,sum}, compares against
//  exact a+b+cin and accumulates error metrics (error count, max/summed error distance).
//  Sits beside any adder under study (Brent-Kung, proposed approximate adders) for FPGA runs.
// PARAMETERS
//  WIDTH    4  adder operand width
//  LATENCY  0  DUT pipeline depth in clk cycles (0 = combinational DUT)
//  (derived) VEC_W = 2*WIDTH+1 index width; CNT_W = VEC_W+1; ED_W = WIDTH+1; ACC_W = VEC_W+ED_W
// PORTS
//  clk        in   1      single clock, all logic rising-edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      begin sweep; sampled only in IDLE/DONE
//  dut_a      out  WIDTH  DUT operand a
//  dut_b      out  WIDTH  DUT operand b
//  dut_cin    out  1      DUT carry-in
//  dut_sum    in   WIDTH  DUT sum
//  dut_cout   in   1      DUT carry-out
//  busy       out  1      high in RUN and DRAIN
//  done       out  1      one-cycle pulse when final result is valid
//  err_count  out  CNT_W  vectors with {cout,sum} != exact
//  max_ed     out  ED_W   max |exact - {cout,sum}|
//  sum_ed     out  ACC_W  sum of |exact - {cout,sum}| over all vectors
// BEHAVIOUR
//  - Reset: FSM=IDLE; all outputs 0 (dut_*, busy, done, err_count, max_ed, sum_ed); idx, valid pipe cleared.
//  - FSM IDLE -> (start) RUN -> (idx==all-ones issued) DRAIN -> (LATENCY cycles; skipped if 0) DONE -> (start) RUN.
//  - start in IDLE/DONE: clears err_count/max_ed/sum_ed, idx=0, enters RUN next cycle. start in RUN/DRAIN ignored.
//  - RUN: one vector per cycle, registered outputs; {dut_a,dut_b,dut_cin} = idx (a MSBs, cin LSB), so
//    order is a outer, b middle, cin inner. idx increments; exactly 2^VEC_W vectors, no wrap re-issue.
//  - Expected value exact = a+b+cin (ED_W bits, zero-extended) and a valid bit travel through a
//    LATENCY-deep shift register aligned with the DUT; compare when delayed valid=1.
//  - approx = {dut_cout,dut_sum}; ed = |exact-approx| computed in ED_W+1 signed, result ED_W bits.
//  - Per valid compare: err_count += (ed!=0); sum_ed += ed; max_ed = max(max_ed, ed). Widths sized so no overflow.
//  - DRAIN: dut_* held at 0; no new vectors; remaining LATENCY compares retire.
//  - done pulses the cycle the FSM enters DONE (one cycle after last compare); busy low from that cycle.
//    Metrics hold stable in DONE until next start.
//  - Timing (LATENCY=L): start high at edge 0 -> first vector on dut_* after edge 1 -> done high after edge 2^VEC_W+L+2.
//  - rst mid-sweep: abort immediately to reset state; no done pulse; metrics cleared.
//  - dut_* are 0 outside RUN.
// STRUCTURE
//  - Package adder_bist_pkg: FSM state enum (IDLE, RUN, DRAIN, DONE), width-derivation functions
//    (VEC_W/CNT_W/ED_W/ACC_W), abs-difference function.
//  - One sub-module: adder_bist_delay_line (LATENCY-deep register of {valid,exact}; pass-through when 0).
//  - Top holds FSM, idx counter, comparator and accumulators.
// TESTING (WIDTH=4 unless noted)
//  1 Exact adder DUT, L=0: start -> done after 514 cycles; err_count=0, max_ed=0, sum_ed=0.
//  2 DUT with dut_cout tied 0: err_count=256, max_ed=16, sum_ed=4096.
//  3 DUT with sum[0] stuck-at-0: err_count=256, max_ed=1, sum_ed=256.
//  4 Exact adder registered twice, LATENCY=2: err_count=0; same DUT with LATENCY=1 -> err_count!=0.
//  5 start re-pulsed at vector 50 of RUN -> ignored, results identical to test 1; start again in DONE
//    -> metrics cleared, second sweep gives same values.
//  6 rst asserted at vector 100 -> next cycle busy=0, done=0, all metrics 0, dut_*=0; no done pulse follows.

Source files
------------

// File: rtl/adder_bist_pkg.sv
// Shared types and helpers for the adder BIST sweeper/analyzer.
package adder_bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic int vec_width(int w);
    return 2 * w + 1;
  endfunction

  function automatic int cnt_width(int w);
    return vec_width(w) + 1;
  endfunction

  function automatic int ed_width(int w);
    return w + 1;
  endfunction

  function automatic int acc_width(int w);
    return vec_width(w) + ed_width(w);
  endfunction

  // Error distance between exact and observed sums, evaluated signed.
  function automatic int unsigned abs_diff(int unsigned x, int unsigned y);
    int d;
    d = int'(x) - int'(y);
    return (d < 0) ? int'(-d) : d;
  endfunction

endpackage

// File: rtl/adder_bist_delay_line.sv
// Aligns {valid, exact} with a LATENCY-deep DUT pipeline; wire-through when LATENCY is 0.
module adder_bist_delay_line #(
  parameter int LATENCY = 0,
  parameter int W       = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  output logic         pending
);

  generate
    if (LATENCY == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_vld  = in_vld;
      assign out_data = in_data;
      assign pending  = 1'b0;
    end else begin : g_pipe
      logic [LATENCY:1]        vld_pipe;
      logic [LATENCY:1][W-1:0] data_pipe;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_pipe  <= '0;
          data_pipe <= '0;
        end else begin
          vld_pipe[1]  <= in_vld;
          data_pipe[1] <= in_data;
          for (int i = LATENCY; i > 1; i--) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            data_pipe[i] <= data_pipe[i-1];
          end
        end
      end

      assign out_vld  = vld_pipe[LATENCY];
      assign out_data = data_pipe[LATENCY];
      assign pending  = |vld_pipe;
    end
  endgenerate

endmodule

// File: rtl/adder_bist_analyzer.sv
// Exhaustive {a,b,cin} sweeper for an adder under study; accumulates error-distance metrics.
module adder_bist_analyzer
  import adder_bist_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [WIDTH-1:0]             dut_a,
  output logic [WIDTH-1:0]             dut_b,
  output logic                         dut_cin,
  input  logic [WIDTH-1:0]             dut_sum,
  input  logic                         dut_cout,
  output logic                         busy,
  output logic                         done,
  output logic [cnt_width(WIDTH)-1:0]  err_count,
  output logic [ed_width(WIDTH)-1:0]   max_ed,
  output logic [acc_width(WIDTH)-1:0]  sum_ed
);

  localparam int VEC_W = vec_width(WIDTH);
  localparam int CNT_W = cnt_width(WIDTH);
  localparam int ED_W  = ed_width(WIDTH);
  localparam int ACC_W = acc_width(WIDTH);

  state_t            state, state_nx;
  logic [VEC_W-1:0]  idx;
  logic              vld_q;
  logic [ED_W-1:0]   exact_q;
  logic              cmp_vld, pending;
  logic [ED_W-1:0]   cmp_exact, approx, ed, exact_nx;
  logic              launch;

  assign launch   = (state == IDLE || state == DONE) && start;
  assign exact_nx = ED_W'(idx[VEC_W-1 -: WIDTH]) + ED_W'(idx[WIDTH:1]) + ED_W'(idx[0]);
  assign approx   = {dut_cout, dut_sum};
  assign ed       = ED_W'(abs_diff(32'(cmp_exact), 32'(approx)));
  assign busy     = (state == RUN) || (state == DRAIN);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = RUN;
      RUN:        if (&idx) state_nx = DRAIN;
      // Leave only once every issued vector has been compared.
      DRAIN:      if (!vld_q && !pending) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      vld_q     <= 1'b0;
      exact_q   <= '0;
      dut_a     <= '0;
      dut_b     <= '0;
      dut_cin   <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
      max_ed    <= '0;
      sum_ed    <= '0;
    end else begin
      done    <= (state == DRAIN) && (state_nx == DONE);
      vld_q   <= (state == RUN);
      exact_q <= exact_nx;
      if (state == RUN) begin
        dut_a   <= idx[VEC_W-1 -: WIDTH];
        dut_b   <= idx[WIDTH:1];
        dut_cin <= idx[0];
        idx     <= idx + 1'b1;
      end else begin
        dut_a   <= '0;
        dut_b   <= '0;
        dut_cin <= 1'b0;
        if (launch) idx <= '0;
      end
      if (launch) begin
        err_count <= '0;
        max_ed    <= '0;
        sum_ed    <= '0;
      end else if (cmp_vld) begin
        err_count <= err_count + CNT_W'(ed != '0);
        sum_ed    <= sum_ed + ACC_W'(ed);
        if (ed > max_ed) max_ed <= ed;
      end
    end
  end

  adder_bist_delay_line #(.LATENCY(LATENCY), .W(ED_W)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (vld_q),
    .in_data  (exact_q),
    .out_vld  (cmp_vld),
    .out_data (cmp_exact),
    .pending  (pending)
  );

endmodule

// File: tb/tb_adder_bist_analyzer.sv
// Scoreboard bench: three analyzer instances (L=0 with selectable faulty adder, L=1/L=2 with a two-stage adder).
module tb_adder_bist_analyzer;

  typedef struct {
    int err;
    int max;
    int sum;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, start_lat;
  int   cyc = 0;
  int   mode = 0;
  int   n_chk = 0, n_fail = 0;
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] a0, b0, sum0, a1, b1, sum1, a2, b2, sum2;
  logic       cin0, cout0, cin1, cout1, cin2, cout2;
  logic       busy0, done0, busy1, done1, busy2, done2;
  logic [9:0] err0, err1, err2;
  logic [4:0] max0, max1, max2;
  logic [13:0] sed0, sed1, sed2;
  logic [4:0] p1 = '0, p1b = '0, p2 = '0, p2b = '0;

  always_comb begin
    {cout0, sum0} = 5'(a0) + 5'(b0) + 5'(cin0);
    if (mode == 1) cout0 = 1'b0;
    if (mode == 2) sum0[0] = 1'b0;
  end

  always @(posedge clk) begin
    p1 <= 5'(a1) + 5'(b1) + 5'(cin1);
    p1b <= p1;
    p2 <= 5'(a2) + 5'(b2) + 5'(cin2);
    p2b <= p2;
  end
  assign {cout1, sum1} = p1b;
  assign {cout2, sum2} = p2b;

  adder_bist_analyzer #(.WIDTH(4), .LATENCY(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .dut_a(a0), .dut_b(b0), .dut_cin(cin0),
    .dut_sum(sum0), .dut_cout(cout0), .busy(busy0), .done(done0),
    .err_count(err0), .max_ed(max0), .sum_ed(sed0));
  adder_bist_analyzer #(.WIDTH(4), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .start(start_lat), .dut_a(a1), .dut_b(b1), .dut_cin(cin1),
    .dut_sum(sum1), .dut_cout(cout1), .busy(busy1), .done(done1),
    .err_count(err1), .max_ed(max1), .sum_ed(sed1));
  adder_bist_analyzer #(.WIDTH(4), .LATENCY(2)) u2 (
    .clk(clk), .rst(rst), .start(start_lat), .dut_a(a2), .dut_b(b2), .dut_cin(cin2),
    .dut_sum(sum2), .dut_cout(cout2), .busy(busy2), .done(done2),
    .err_count(err2), .max_ed(max2), .sum_ed(sed2));

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_res(string tag, exp_t e, int err, int mx, int sm);
    chk({tag, "_done_cycle"}, cyc, e.cyc);
    chk({tag, "_err_count"}, err, e.err);
    chk({tag, "_max_ed"}, mx, e.max);
    chk({tag, "_sum_ed"}, sm, e.sum);
  endtask

  task automatic spurious(string tag);
    n_chk++;
    n_fail++;
    $display("FAIL %s_unexpected_done: got done=1 expected no pulse (t=%0t)", tag, $time);
  endtask

  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      if (q0.size() == 0) spurious("u0");
      else chk_res("u0", q0.pop_front(), int'(err0), int'(max0), int'(sed0));
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) spurious("u1");
      else chk_res("u1", q1.pop_front(), int'(err1), int'(max1), int'(sed1));
    end
    if (done2 === 1'b1) begin
      if (q2.size() == 0) spurious("u2");
      else chk_res("u2", q2.pop_front(), int'(err2), int'(max2), int'(sed2));
    end
  end

  // Issue a sweep on u0 (optionally u1/u2 too); start is sampled at the next edge.
  task automatic go(int err, int mx, int sm, bit with_lat);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    e = '{err, mx, sm, cyc + 1 + 514};
    q0.push_back(e);
    if (with_lat) begin
      start_lat = 1'b1;
      q1.push_back('{271, 15, 481, cyc + 1 + 515});
      q2.push_back('{0, 0, 0, cyc + 1 + 516});
    end
    @(negedge clk);
    start = 1'b0;
    start_lat = 1'b0;
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      @(negedge clk);
      t++;
      if (t > 2000) begin
        n_chk++;
        n_fail++;
        $display("FAIL done_timeout: got no done within %0d cycles expected done", t);
        q0.delete(); q1.delete(); q2.delete();
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_done"}, done0, 0);
    chk({tag, "_err"}, err0, 0);
    chk({tag, "_max"}, max0, 0);
    chk({tag, "_sum"}, sed0, 0);
    chk({tag, "_dut"}, {a0, b0, cin0}, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_lat = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_u1_busy", busy1, 0);
    rst = 1'b0;

    // Exact adder on all three; L=1 misaligned against a two-stage DUT.
    mode = 0;
    go(0, 0, 0, 1'b1);
    wait_empty();

    // start re-pulsed mid-RUN must be ignored.
    go(0, 0, 0, 1'b0);
    repeat (50) @(negedge clk);
    chk("run_busy", busy0, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_empty();

    // cout tied low, swept twice back-to-back from DONE (metrics must clear).
    mode = 1;
    go(256, 16, 4096, 1'b0);
    wait_empty();
    chk("done_hold_sum", sed0, 4096);
    go(256, 16, 4096, 1'b0);
    wait_empty();

    // sum[0] stuck at 0.
    mode = 2;
    go(256, 1, 256, 1'b0);
    wait_empty();

    // Reset while vector 100 is on the DUT.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (101) @(negedge clk);
    chk("v100_dut_a", a0, 3);
    chk("v100_dut_b", b0, 2);
    chk("v100_dut_cin", cin0, 0);
    chk("v100_err", err0, 50);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("abort");
    repeat (600) @(negedge clk);
    chk("abort_busy_after", busy0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
